sd_sector_arbiter: RTL and testbench
====================================

Name: sd_sector_arbiter

Overview:
- Shares the HPS virtual-disk sector channel between the two floppy drive requesters in the TRS-80 FDC path (drive 0 and drive 1).
- Accepts per-drive sector read/write requests with LBA, serialises them one sector at a time, and drives hps_io's per-drive sd_rd/sd_wr lines with a single shared sd_lba.
- Reports the granted drive so the sector-buffer mux and sd_buff_din routing follow the active transfer.
- Sits between the trs80 core's FDC and hps_io.

Parameters:
- NDRV, 2, number of requesting drives; fixed at 2 in this revision.
- TIMEOUT_CYCLES, 42000000, cycles to wait for sd_ack rise before abort (1 s at 42 MHz); used only with SD_TIMEOUT_EN.

Ports:
- clk_sys  in  1  system clock, 42 MHz.
- reset_n  in  1  asynchronous active-low reset.
- req_rd  in  2  per-drive sector read request; level, held until req_done/req_err.
- req_wr  in  2  per-drive sector write request; level, held until req_done/req_err.
- req_lba_0  in  32  drive 0 sector LBA; stable while request is held.
- req_lba_1  in  32  drive 1 sector LBA.
- img_mounted  in  2  hps_io mount/eject strobe per drive.
- sd_ack  in  2  hps_io per-drive acknowledge.
- sd_rd  out  2  hps_io per-drive read request.
- sd_wr  out  2  hps_io per-drive write request.
- sd_lba  out  32  LBA of the granted drive, registered.
- grant  out  2  one-hot active drive; 0 when idle.
- busy  out  1  transfer in progress.
- req_done  out  2  one-cycle completion pulse per drive.
- req_err  out  2  one-cycle abort pulse per drive.

Behaviour:
- Reset (async, reset_n low): state IDLE; sd_rd, sd_wr, grant, req_done, req_err = 0; sd_lba = 0; busy = 0; rr_last = drive 1, so drive 0 wins first.
- States: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - pending[i] = req_rd[i] | req_wr[i], masked while req_done/req_err for i is pulsing.
  - Round-robin: prefer the drive not equal to rr_last; fall back to the other drive.
  - On selection, in the same edge: latch grant, sd_lba, op (read if req_rd set, else write); enter ISSUE.
  - Latency from request to sd_rd/sd_wr high: 2 cycles (select, then issue).
- ISSUE:
  - Assert sd_rd[g] or sd_wr[g] (exactly one bit, never both) until sd_ack[g] is sampled high.
  - Then deassert the request and enter XFER.
  - sd_ack on a non-granted drive is ignored.
- XFER: hold grant and sd_lba; wait for sd_ack[g] low, then enter DONE.
- DONE: pulse req_done[g] for 1 cycle; set rr_last = g; clear grant; return to IDLE. No back-to-back grant on the DONE cycle.
- busy = (state != IDLE).
- Simultaneous req_rd and req_wr on one drive: read wins; the write stays pending for a later grant.
- Both drives request in the same cycle: round-robin decides; the loser waits exactly one transfer.
- img_mounted[g] strobe:
  - In ISSUE: drop the request, pulse req_err[g], return to IDLE.
  - In XFER: ignored; let hps_io finish the sector.
- Request withdrawn mid-ISSUE or mid-XFER: ignored; the transfer completes and req_done still pulses.
- sd_lba is registered at grant and never follows req_lba_x changes mid-transfer.

Optional Feature:
- Macro: SD_TIMEOUT_EN.
- With it: a counter starts on entry to ISSUE. At TIMEOUT_CYCLES-1 without sd_ack[g]: deassert sd_rd/sd_wr, pulse req_err[g], go to IDLE, set rr_last = g.
- Without it: no counter; ISSUE waits indefinitely. req_err is driven only by img_mounted.

Decomposition:
- Package sd_arb_pkg:
  - state enum (IDLE, ISSUE, XFER, DONE).
  - localparam NDRV = 2.
  - op typedef (OP_RD, OP_WR).
  - default TIMEOUT_CYCLES constant.
- One sub-module: sd_rr_pick. Combinational 2-way round-robin picker taking pending[1:0] and rr_last, returning one-hot pick and valid. Reused later for the download-port arbiter.

Test Plan:
- Single read: req_rd=01, req_lba_0=0x12. Expect sd_rd=01 and sd_lba=0x12 two cycles later. After sd_ack=01 high for 3 cycles then low: sd_rd already 0; req_done=01 for one cycle; grant=00.
- Concurrent requests: req_rd=11 after reset. Drive 0 is served first, then drive 1. Repeat with both held: grants alternate 0,1,0,1.
- Same drive rd+wr: req_rd[1]=req_wr[1]=1. First transfer is sd_rd=10, never sd_wr=10 in the same cycle. Keep req_wr only: next transfer is sd_wr=10.
- Eject: img_mounted[0] pulse during ISSUE gives req_err=01 and sd_rd=00 next cycle. Same pulse during XFER gives no error and a normal req_done.
- Reset: drop reset_n during XFER. All outputs are 0 immediately (asynchronous). After release, a pending req_rd=10 restarts from IDLE.
- Timeout (SD_TIMEOUT_EN, TIMEOUT_CYCLES=16): no sd_ack. req_err pulses 16 cycles after sd_rd rises, and sd_rd falls in the same cycle.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the HPS sector-channel arbiter and its picker.
package sd_arb_pkg;

    localparam int NDRV = 2;
    localparam int unsigned TIMEOUT_DEF = 32'd42000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/sd_rr_pick.sv
// Two-way round-robin picker: favours the requester that was not served last.
module sd_rr_pick (
    input  logic [1:0] pending_i,
    input  logic       rr_last_i,
    output logic [1:0] pick_o,
    output logic       valid_o
);

    logic pref;
    assign pref = ~rr_last_i;

    always_comb begin
        pick_o = 2'b00;
        if (pending_i[pref]) begin
            pick_o[pref] = 1'b1;
        end else if (pending_i[rr_last_i]) begin
            pick_o[rr_last_i] = 1'b1;
        end
    end

    assign valid_o = |pending_i;

endmodule

// File: rtl/sd_sector_arbiter.sv
// Serialises per-drive sector requests onto the shared hps_io sector channel.
// Optional ISSUE-phase ack timeout is enabled with `define SD_TIMEOUT_EN.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic [NDRV-1:0] req_rd,
    input  logic [NDRV-1:0] req_wr,
    input  logic [31:0]     req_lba_0,
    input  logic [31:0]     req_lba_1,
    input  logic [NDRV-1:0] img_mounted,
    input  logic [NDRV-1:0] sd_ack,
    output logic [NDRV-1:0] sd_rd,
    output logic [NDRV-1:0] sd_wr,
    output logic [31:0]     sd_lba,
    output logic [NDRV-1:0] grant,
    output logic            busy,
    output logic [NDRV-1:0] req_done,
    output logic [NDRV-1:0] req_err
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [NDRV-1:0] grant_q, grant_d;
    logic [31:0]     lba_q, lba_d;
    logic            rr_last_q, rr_last_d;
    logic [NDRV-1:0] sd_rd_q, sd_rd_d;
    logic [NDRV-1:0] sd_wr_q, sd_wr_d;
    logic [NDRV-1:0] done_q, done_d;
    logic [NDRV-1:0] err_q, err_d;

    logic [NDRV-1:0] pending;
    logic [NDRV-1:0] pick;
    logic            pick_vld;
    logic            ack_g;
    logic            eject_g;
    logic            tmo_hit;

    // A drive whose completion/abort is still pulsing has not yet dropped its request.
    assign pending = (req_rd | req_wr) & ~(done_q | err_q);
    assign ack_g   = |(sd_ack & grant_q);
    assign eject_g = |(img_mounted & grant_q);

    sd_rr_pick u_pick (
        .pending_i (pending),
        .rr_last_i (rr_last_q),
        .pick_o    (pick),
        .valid_o   (pick_vld)
    );

`ifdef SD_TIMEOUT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
        end else if (state_q != ST_ISSUE) begin
            cnt_q <= 32'd0;
        end else if (|(sd_rd_q | sd_wr_q)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Counts cycles with the request line up, so the abort lands TIMEOUT_CYCLES after it rises.
    assign tmo_hit = (state_q == ST_ISSUE) && (|(sd_rd_q | sd_wr_q)) &&
                     (cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        grant_d   = grant_q;
        lba_d     = lba_q;
        rr_last_d = rr_last_q;
        sd_rd_d   = sd_rd_q;
        sd_wr_d   = sd_wr_q;
        done_d    = 2'b00;
        err_d     = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    lba_d   = pick[1] ? req_lba_1 : req_lba_0;
                    op_d    = (|(req_rd & pick)) ? OP_RD : OP_WR;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (eject_g) begin
                    sd_rd_d = 2'b00;
                    sd_wr_d = 2'b00;
                    err_d   = grant_q;
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end else if (ack_g) begin
                    sd_rd_d = 2'b00;
                    sd_wr_d = 2'b00;
                    state_d = ST_XFER;
                end else if (tmo_hit) begin
                    sd_rd_d   = 2'b00;
                    sd_wr_d   = 2'b00;
                    err_d     = grant_q;
                    rr_last_d = grant_q[1];
                    grant_d   = 2'b00;
                    state_d   = ST_IDLE;
                end else begin
                    sd_rd_d = (op_q == OP_RD) ? grant_q : 2'b00;
                    sd_wr_d = (op_q == OP_WR) ? grant_q : 2'b00;
                end
            end
            ST_XFER: begin
                if (!ack_g) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d    = grant_q;
                rr_last_d = grant_q[1];
                grant_d   = 2'b00;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RD;
            grant_q   <= 2'b00;
            lba_q     <= 32'd0;
            rr_last_q <= 1'b1;
            sd_rd_q   <= 2'b00;
            sd_wr_q   <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            grant_q   <= grant_d;
            lba_q     <= lba_d;
            rr_last_q <= rr_last_d;
            sd_rd_q   <= sd_rd_d;
            sd_wr_q   <= sd_wr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sd_rd    = sd_rd_q;
    assign sd_wr    = sd_wr_q;
    assign sd_lba   = lba_q;
    assign grant    = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign req_done = done_q;
    assign req_err  = err_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter; timeout case runs when SD_TIMEOUT_EN is defined.
module tb_sd_sector_arbiter;

    localparam int unsigned TMO = 16;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  req_rd = 2'b00;
    logic [1:0]  req_wr = 2'b00;
    logic [31:0] req_lba_0 = 32'd0;
    logic [31:0] req_lba_1 = 32'd0;
    logic [1:0]  img_mounted = 2'b00;
    logic [1:0]  sd_ack = 2'b00;
    logic [1:0]  sd_rd;
    logic [1:0]  sd_wr;
    logic [31:0] sd_lba;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  req_done;
    logic [1:0]  req_err;

    int n_chk = 0;
    int n_bad = 0;

    sd_sector_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_lba_0   (req_lba_0),
        .req_lba_1   (req_lba_1),
        .img_mounted (img_mounted),
        .sd_ack      (sd_ack),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_lba      (sd_lba),
        .grant       (grant),
        .busy        (busy),
        .req_done    (req_done),
        .req_err     (req_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_rd = 2'b00; req_wr = 2'b00; sd_ack = 2'b00; img_mounted = 2'b00;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    // Acks while sd_rd/sd_wr is up, releases, then lands on the cycle where req_done pulses.
    task automatic xfer_ack(input logic [1:0] drv);
        sd_ack = drv;
        tick(1);
        sd_ack = 2'b00;
        tick(2);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_sd_rd", sd_rd, 2'b00);
        chk("rst_sd_wr", sd_wr, 2'b00);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_done", req_done, 2'b00);
        chk("rst_err", req_err, 2'b00);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // single read on drive 0
        req_rd = 2'b01; req_lba_0 = 32'h12;
        tick(1);
        chk("rd1_grant", grant, 2'b01);
        chk("rd1_rd_early", sd_rd, 2'b00);
        chk("rd1_busy", busy, 1'b1);
        tick(1);
        chk("rd1_sd_rd", sd_rd, 2'b01);
        chk("rd1_lba", sd_lba, 32'h12);
        sd_ack = 2'b01;
        tick(1);
        chk("rd1_rd_off", sd_rd, 2'b00);
        tick(2);
        sd_ack = 2'b00;
        tick(1);
        chk("rd1_done_early", req_done, 2'b00);
        tick(1);
        chk("rd1_done", req_done, 2'b01);
        chk("rd1_grant_clr", grant, 2'b00);
        chk("rd1_busy_clr", busy, 1'b0);
        req_rd = 2'b00;
        tick(1);
        chk("rd1_done_1cyc", req_done, 2'b00);

        // both drives held: grants alternate 0,1,0,1
        do_reset();
        req_rd = 2'b11; req_lba_0 = 32'hA0; req_lba_1 = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  eg;
            logic [31:0] el;
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            el = (i % 2 == 0) ? 32'hA0 : 32'hB1;
            tick(1);
            chk("rr_grant", grant, eg);
            tick(1);
            chk("rr_sd_rd", sd_rd, eg);
            chk("rr_sd_wr", sd_wr, 2'b00);
            chk("rr_lba", sd_lba, el);
            xfer_ack(eg);
            chk("rr_done", req_done, eg);
        end
        req_rd = 2'b00;
        tick(1);
        chk("rr_idle", busy, 1'b0);

        // drive 1 read+write: read first, write afterwards
        req_rd = 2'b10; req_wr = 2'b10; req_lba_1 = 32'h77;
        tick(2);
        chk("rw_sd_rd", sd_rd, 2'b10);
        chk("rw_sd_wr", sd_wr, 2'b00);
        xfer_ack(2'b10);
        chk("rw_done", req_done, 2'b10);
        req_rd = 2'b00;
        tick(1);
        chk("rw_masked", busy, 1'b0);
        tick(2);
        chk("wr_sd_wr", sd_wr, 2'b10);
        chk("wr_sd_rd", sd_rd, 2'b00);
        xfer_ack(2'b10);
        chk("wr_done", req_done, 2'b10);
        req_wr = 2'b00;
        tick(1);

        // eject during ISSUE aborts
        req_rd = 2'b01; req_lba_0 = 32'h21;
        tick(2);
        chk("ej_sd_rd", sd_rd, 2'b01);
        img_mounted = 2'b01;
        tick(1);
        img_mounted = 2'b00;
        chk("ej_err", req_err, 2'b01);
        chk("ej_rd_off", sd_rd, 2'b00);
        chk("ej_no_done", req_done, 2'b00);
        chk("ej_grant", grant, 2'b00);
        req_rd = 2'b00;
        tick(1);
        chk("ej_err_1cyc", req_err, 2'b00);

        // eject during XFER ignored; foreign ack ignored; LBA held
        req_rd = 2'b01; req_lba_0 = 32'h55;
        tick(1);
        req_lba_0 = 32'h99;
        tick(1);
        sd_ack = 2'b10;
        tick(1);
        chk("fx_ack_ignored", sd_rd, 2'b01);
        chk("fx_lba_held", sd_lba, 32'h55);
        sd_ack = 2'b01;
        tick(1);
        img_mounted = 2'b01;
        tick(1);
        img_mounted = 2'b00;
        chk("ex_no_err", req_err, 2'b00);
        chk("ex_busy", busy, 1'b1);
        sd_ack = 2'b00;
        tick(2);
        chk("ex_done", req_done, 2'b01);
        chk("ex_err0", req_err, 2'b00);
        req_rd = 2'b00;
        tick(1);

        // asynchronous reset mid-XFER, pending request restarts
        req_rd = 2'b10; req_lba_1 = 32'hABCD;
        tick(2);
        sd_ack = 2'b10;
        tick(1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_grant", grant, 2'b00);
        chk("ar_lba", sd_lba, 32'd0);
        sd_ack = 2'b00;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        chk("ar_regrant", grant, 2'b10);
        tick(1);
        chk("ar_sd_rd", sd_rd, 2'b10);
        chk("ar_lba2", sd_lba, 32'hABCD);
        xfer_ack(2'b10);
        chk("ar_done", req_done, 2'b10);
        req_rd = 2'b00;
        tick(1);

`ifdef SD_TIMEOUT_EN
        do_reset();
        req_rd = 2'b01; req_lba_0 = 32'h3;
        tick(2);
        chk("to_sd_rd", sd_rd, 2'b01);
        tick(15);
        chk("to_rd_hold", sd_rd, 2'b01);
        chk("to_err_early", req_err, 2'b00);
        tick(1);
        chk("to_err", req_err, 2'b01);
        chk("to_rd_off", sd_rd, 2'b00);
        req_rd = 2'b00;
        tick(1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
